// File: rtl/q_srl_mc_arb_if.sv
// Bundle of the per-channel push side and the shared arbitrated pop side of q_srl_mc_arb.
interface q_srl_mc_arb_if #(
  parameter int CH    = 4,
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(CH);

  logic [CH*WIDTH-1:0] i_d;
  logic [CH-1:0]       i_v;
  logic [CH-1:0]       i_b;
  logic [CH-1:0]       i_af;
  logic [CH-1:0]       flush;
  logic [CH*CW-1:0]    cnt;
  logic [WIDTH-1:0]    o_d;
  logic [IW-1:0]       o_ch;
  logic                o_v;
  logic                o_b;

  modport master (
    output i_d, i_v, flush, o_b,
    input  i_b, i_af, cnt, o_d, o_ch, o_v
  );

  modport slave (
    input  i_d, i_v, flush, o_b,
    output i_b, i_af, cnt, o_d, o_ch, o_v
  );
endinterface

// File: rtl/q_srl_mc_arb.sv
// CH shift-register FIFOs drained through one round-robin port with stall lock.
// Define Q_SRL_MC_PRIO_EN to give channel 0 strict priority over the round-robin group.
module q_srl_mc_arb #(
  parameter int CH     = 4,
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 16,
  parameter int AF_LVL = DEPTH - 2
) (
  input logic           clock,
  input logic           reset,
  q_srl_mc_arb_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(CH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_p0 [CH][DEPTH];
  logic [CW-1:0]    cnt_p0 [CH];
  logic [IW-1:0]    rr_ptr_p0;
  logic [IW-1:0]    lock_ch_p0;
  logic             lock_p0;

  logic [CH-1:0]    nonempty;
  logic [CH-1:0]    push;
  logic [IW-1:0]    grant;
  logic [AW-1:0]    head_idx;
  logic             any_v;
  logic             pop;

  // Saturating occupancy update: never above DEPTH, never below zero.
  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] c,
                                             input logic inc, input logic dec);
    if (inc && !dec && c != CW'(DEPTH)) return c + CW'(1);
    if (dec && !inc && c != '0)         return c - CW'(1);
    return c;
  endfunction

  always_comb begin
    nonempty = '0;
    push     = '0;
    bus.i_b  = '0;
    bus.i_af = '0;
    bus.cnt  = '0;
    for (int c = 0; c < CH; c++) begin
      nonempty[c]          = (cnt_p0[c] != '0);
      bus.i_b[c]           = (cnt_p0[c] == CW'(DEPTH));
      bus.i_af[c]          = (cnt_p0[c] >= CW'(AF_LVL));
      push[c]              = bus.i_v[c] & ~bus.i_b[c];
      bus.cnt[c*CW +: CW]  = cnt_p0[c];
    end
  end

  always_comb begin : arb_comb
    logic          found;
    logic [IW-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (lock_p0) begin
      grant = lock_ch_p0;
      found = 1'b1;
    end
`ifdef Q_SRL_MC_PRIO_EN
    else if (nonempty[0]) begin
      grant = '0;
      found = 1'b1;
    end
    // Round-robin ring is channels 1..CH-1 only.
    for (int i = 1; i < CH; i++) begin
      idx = IW'(((int'(rr_ptr_p0) + i + CH - 2) % (CH - 1)) + 1);
      if (!found && nonempty[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
`else
    for (int i = 1; i <= CH; i++) begin
      idx = IW'((int'(rr_ptr_p0) + i) % CH);
      if (!found && nonempty[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
`endif
  end

  assign any_v    = |nonempty;
  assign pop      = any_v & ~bus.o_b;
  assign head_idx = AW'(cnt_p0[grant] - CW'(1));
  assign bus.o_v  = any_v;
  assign bus.o_ch = any_v ? grant : '0;
  assign bus.o_d  = any_v ? mem_p0[grant][head_idx] : '0;

  // ---- p0: occupancy, arbitration pointer and stall lock ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) cnt_p0[c] <= '0;
      rr_ptr_p0  <= IW'(CH - 1);
      lock_p0    <= 1'b0;
      lock_ch_p0 <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (bus.flush[c]) cnt_p0[c] <= '0;
        else              cnt_p0[c] <= cnt_step(cnt_p0[c], push[c], pop && (grant == IW'(c)));
      end
      if (pop) begin
`ifdef Q_SRL_MC_PRIO_EN
        if (grant != '0) rr_ptr_p0 <= grant;
`else
        rr_ptr_p0 <= grant;
`endif
      end
      // Never hold a lock on a channel that is being emptied this edge.
      if (pop || bus.flush[grant]) begin
        lock_p0 <= 1'b0;
      end else if (any_v) begin
        lock_p0    <= 1'b1;
        lock_ch_p0 <= grant;
      end
    end
  end

  // ---- p0: data shift registers (no reset; validity tracked by cnt_p0) ----
  always_ff @(posedge clock) begin
    for (int c = 0; c < CH; c++) begin
      if (push[c]) begin
        mem_p0[c][0] <= bus.i_d[c*WIDTH +: WIDTH];
        for (int k = 1; k < DEPTH; k++) mem_p0[c][k] <= mem_p0[c][k-1];
      end
    end
  end
endmodule

// File: tb/tb_q_srl_mc_arb.sv
// Bench for q_srl_mc_arb: queue-based reference model compared every cycle, plus directed literal checks.
module tb_q_srl_mc_arb;
  localparam int CH     = 4;
  localparam int DEPTH  = 16;
  localparam int WIDTH  = 16;
  localparam int AF_LVL = DEPTH - 2;
  localparam int CW     = $clog2(DEPTH + 1);

  logic clock;
  logic reset;
  int   passed;
  int   total;

  q_srl_mc_arb_if #(.CH(CH), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  q_srl_mc_arb #(.CH(CH), .DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LVL(AF_LVL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: one queue per channel, front = oldest entry.
  logic [WIDTH-1:0] mq [CH][$];
  int               m_rr;
  bit               m_lock;
  int               m_lock_ch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) mq[c].delete();
    m_rr      = CH - 1;
    m_lock    = 1'b0;
    m_lock_ch = 0;
  endfunction

  function automatic int m_grant();
    if (m_lock) return m_lock_ch;
`ifdef Q_SRL_MC_PRIO_EN
    if (mq[0].size() != 0) return 0;
`endif
    for (int k = 1; k <= CH; k++) begin
      int c;
      c = (m_rr + k) % CH;
`ifdef Q_SRL_MC_PRIO_EN
      if (c == 0) continue;
`endif
      if (mq[c].size() != 0) return c;
    end
    return 0;
  endfunction

  function automatic bit m_any();
    for (int c = 0; c < CH; c++) if (mq[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step(input int g, input bit anyv);
    bit pop;
    bit [CH-1:0] acc;
    pop = anyv && !bus.o_b;
    for (int c = 0; c < CH; c++) acc[c] = bus.i_v[c] && (mq[c].size() < DEPTH);
    if (pop || bus.flush[g]) m_lock = 1'b0;
    else if (anyv) begin
      m_lock    = 1'b1;
      m_lock_ch = g;
    end
`ifdef Q_SRL_MC_PRIO_EN
    if (pop && g != 0) m_rr = g;
`else
    if (pop) m_rr = g;
`endif
    for (int c = 0; c < CH; c++) begin
      if (bus.flush[c]) mq[c].delete();
      else begin
        if (pop && g == c) void'(mq[c].pop_front());
        if (acc[c]) mq[c].push_back(bus.i_d[c*WIDTH +: WIDTH]);
      end
    end
  endfunction

  // Compare process: outputs are state-only, so check mid-cycle then advance the model.
  initial begin
    int               g;
    bit               anyv;
    logic [CH*CW-1:0] e_cnt;
    logic [CH-1:0]    e_ib, e_af;
    model_reset();
    forever begin
      @(negedge clock);
      if (!reset) model_reset();
      g    = m_grant();
      anyv = m_any();
      for (int c = 0; c < CH; c++) begin
        e_cnt[c*CW +: CW] = CW'(mq[c].size());
        e_ib[c]           = (mq[c].size() == DEPTH);
        e_af[c]           = (mq[c].size() >= AF_LVL);
      end
      chk("m_o_v", 32'(bus.o_v), 32'(anyv));
      chk("m_o_ch", 32'(bus.o_ch), anyv ? 32'(g) : 32'd0);
      chk("m_o_d", 32'(bus.o_d), anyv ? 32'(mq[g][0]) : 32'd0);
      chk("m_cnt", 32'(bus.cnt), 32'(e_cnt));
      chk("m_i_b", 32'(bus.i_b), 32'(e_ib));
      chk("m_i_af", 32'(bus.i_af), 32'(e_af));
      if (reset) model_step(g, anyv);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.i_v   = '0;
    bus.flush = '0;
    bus.i_d   = '0;
  endtask

  task automatic push(input int c, input logic [WIDTH-1:0] d);
    bus.i_v[c]             = 1'b1;
    bus.i_d[c*WIDTH +: WIDTH] = d;
  endtask

  task automatic reset_pulse();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] cnt_of(input int c);
    return 32'(bus.cnt[c*CW +: CW]);
  endfunction

  initial begin
    int seq [8];
`ifdef Q_SRL_MC_PRIO_EN
    seq = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
    seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    passed  = 0;
    total   = 0;
    reset   = 1'b0;
    bus.o_b = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_cnt", 32'(bus.cnt), 32'd0);
    chk("rst_i_b", 32'(bus.i_b), 32'd0);
    chk("rst_i_af", 32'(bus.i_af), 32'd0);
    chk("rst_o_v", 32'(bus.o_v), 32'd0);
    chk("rst_o_ch", 32'(bus.o_ch), 32'd0);
    reset = 1'b1;

    // Two words through ch0 with no stall.
    push(0, 16'hA1);
    tick();
    chk("t1_o_v", 32'(bus.o_v), 32'd1);
    chk("t1_d0", 32'(bus.o_d), 32'hA1);
    chk("t1_ch", 32'(bus.o_ch), 32'd0);
    push(0, 16'hA2);
    tick();
    idle();
    chk("t1_d1", 32'(bus.o_d), 32'hA2);
    chk("t1_cnt1", cnt_of(0), 32'd1);
    tick();
    chk("t1_cnt0", cnt_of(0), 32'd0);
    chk("t1_empty", 32'(bus.o_v), 32'd0);

    // Fill ch1 under stall, overfill, then drain in order.
    bus.o_b = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      push(1, 16'(16'h100 + k));
      tick();
      if (k + 1 == AF_LVL - 1) chk("t2_af_lo", 32'(bus.i_af[1]), 32'd0);
      if (k + 1 == AF_LVL)     chk("t2_af_hi", 32'(bus.i_af[1]), 32'd1);
    end
    chk("t2_full", 32'(bus.i_b[1]), 32'd1);
    push(1, 16'h1FF);
    tick();
    idle();
    chk("t2_ovf_cnt", cnt_of(1), 32'(DEPTH));
    chk("t2_head", 32'(bus.o_d), 32'h100);
    bus.o_b = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      chk("t2_drain", 32'(bus.o_d), 32'(16'h100 + k));
      tick();
    end
    chk("t2_done", 32'(bus.o_v), 32'd0);

    // Round-robin order over four loaded channels.
    reset_pulse();
    bus.o_b = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < CH; c++) push(c, 16'((c << 4) | r));
      tick();
    end
    idle();
    bus.o_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("t3_rr_ch", 32'(bus.o_ch), 32'(seq[k]));
      tick();
    end

    // Lock holds ch2 while ch0 becomes ready.
    reset_pulse();
    bus.o_b = 1'b1;
    push(2, 16'h2A);
    tick();
    push(2, 16'h2B);
    tick();
    idle();
    chk("t4_ch", 32'(bus.o_ch), 32'd2);
    push(0, 16'h0C);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      chk("t4_lock_ch", 32'(bus.o_ch), 32'd2);
      chk("t4_lock_d", 32'(bus.o_d), 32'h2A);
      tick();
    end
    bus.o_b = 1'b0;
    tick();
    chk("t4_pop2", cnt_of(2), 32'd1);
    chk("t4_keep0", cnt_of(0), 32'd1);
    chk("t4_next", 32'(bus.o_ch), 32'd0);

    // Flush beats a same-cycle push and frees the lock.
    reset_pulse();
    bus.o_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(3, 16'(16'h30 + k));
      tick();
    end
    idle();
    chk("t5_cnt5", cnt_of(3), 32'd5);
    chk("t5_ch3", 32'(bus.o_ch), 32'd3);
    bus.flush[3] = 1'b1;
    push(3, 16'h3F);
    tick();
    idle();
    chk("t5_flushed", cnt_of(3), 32'd0);
    chk("t5_ov", 32'(bus.o_v), 32'd0);
    push(1, 16'h11);
    tick();
    idle();
    chk("t5_unlock_ch", 32'(bus.o_ch), 32'd1);
    chk("t5_unlock_d", 32'(bus.o_d), 32'h11);
    bus.o_b = 1'b0;
    tick();

    // Asynchronous reset in the middle of traffic.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < CH; c++) push(c, 16'($urandom));
      tick();
    end
    @(posedge clock);
    #3;
    idle();
    reset = 1'b0;
    #1;
    chk("t6_o_v", 32'(bus.o_v), 32'd0);
    chk("t6_cnt", 32'(bus.cnt), 32'd0);
    chk("t6_i_b", 32'(bus.i_b), 32'd0);
    tick();
    reset = 1'b1;

    // Randomized traffic with varying stall and load mixes.
    for (int n = 0; n < 3000; n++) begin
      int ph;
      ph = n / 500;
      idle();
      for (int c = 0; c < CH; c++) begin
        bus.i_v[c]   = ($urandom_range(99) < ((ph % 2) ? 70 : 35));
        bus.flush[c] = ($urandom_range(59) == 0);
        bus.i_d[c*WIDTH +: WIDTH] = 16'($urandom);
      end
      bus.o_b = ($urandom_range(99) < ((ph % 3 == 0) ? 80 : 30));
      tick();
    end
    idle();
    bus.o_b = 1'b0;
    tick();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
